leve_trap_seq: RTL and testbench

Trap sequencer and port arbiter for the CSR register file. It owns the file's single command port (CMD/CSR_A/CSR_WD/CSR_RD) and shares it between pipeline CSR instructions and the trap entry/return sequences. Exception entry performs the multi-cycle mepc/mcause/mtval/mstatus update and reads mtvec. MRET performs the mstatus restore and reads mepc. The block then issues a one-cycle front-end redirect.

---
 rtl/leve_trap_seq_if.sv | 20 ++
 rtl/leve_trap_seq.sv | 158 +++++++++++++++
 tb/tb_leve_trap_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/leve_trap_seq_if.sv
// CSR register-file command port shared by the trap sequencer (master) and the CSR file (slave).
// Also defines the `CSR_* command encodings used on CSR_CMD and INST_CMD.
`ifndef CSR_NONE
`define CSR_NONE  2'b00
`define CSR_SET   2'b01
`define CSR_CLEAR 2'b10
`define CSR_WRITE 2'b11
`endif

interface leve_trap_seq_if #(
    parameter int XLEN = 64
);
    logic [1:0]      CSR_CMD;
    logic [11:0]     CSR_A;
    logic [XLEN-1:0] CSR_WD;
    logic [XLEN-1:0] CSR_RD;

    modport master (output CSR_CMD, output CSR_A, output CSR_WD, input CSR_RD);
    modport slave  (input CSR_CMD, input CSR_A, input CSR_WD, output CSR_RD);
endinterface

// File: rtl/leve_trap_seq.sv
// Trap sequencer / CSR port arbiter: CSR instructions, exception entry and MRET on one port.
// Define LEVE_TRAP_TVAL_EN to include the mtval write state (X_TVAL).
module leve_trap_seq #(
    parameter int XLEN = 64
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            INST_REQ,
    input  logic [1:0]      INST_CMD,
    input  logic [11:0]     INST_A,
    input  logic [XLEN-1:0] INST_WD,
    output logic            INST_ACK,
    output logic [XLEN-1:0] INST_RD,
    input  logic            EXC_REQ,
    input  logic [XLEN-1:0] EXC_CAUSE,
    input  logic [XLEN-1:0] EXC_PC,
    input  logic [XLEN-1:0] EXC_TVAL,
    input  logic            RET_REQ,
    output logic            BUSY,
    output logic            REDIRECT,
    output logic [XLEN-1:0] REDIRECT_PC,
    leve_trap_seq_if.master csr
);

    typedef enum logic [3:0] {
        IDLE, I_ACC, X_EPC, X_CAUSE, X_TVAL, X_STAT, X_VEC, R_STAT, R_EPC, DONE
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      cap_cmd;
    logic [11:0]     cap_a;
    logic [XLEN-1:0] cap_wd, cap_cause, cap_pc;
    logic [XLEN-1:0] redirect_pc_q;
`ifdef LEVE_TRAP_TVAL_EN
    logic [XLEN-1:0] cap_tval;
`else
    logic            unused_tval;
    assign unused_tval = ^EXC_TVAL;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Operands are frozen at acceptance; later changes on the request ports are ignored.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cap_cmd       <= `CSR_NONE;
            cap_a         <= '0;
            cap_wd        <= '0;
            cap_cause     <= '0;
            cap_pc        <= '0;
`ifdef LEVE_TRAP_TVAL_EN
            cap_tval      <= '0;
`endif
            redirect_pc_q <= '0;
        end else begin
            if (state_q == IDLE && (EXC_REQ || RET_REQ || INST_REQ)) begin
                cap_cmd   <= INST_CMD;
                cap_a     <= INST_A;
                cap_wd    <= INST_WD;
                cap_cause <= EXC_CAUSE;
                cap_pc    <= EXC_PC;
`ifdef LEVE_TRAP_TVAL_EN
                cap_tval  <= EXC_TVAL;
`endif
            end
            // Direct mode only: mtvec mode bits are dropped.
            if (state_q == X_VEC) redirect_pc_q <= {csr.CSR_RD[XLEN-1:2], 2'b00};
            if (state_q == R_EPC) redirect_pc_q <= csr.CSR_RD;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        csr.CSR_CMD = `CSR_NONE;
        csr.CSR_A   = '0;
        csr.CSR_WD  = '0;
        INST_ACK    = 1'b0;
        INST_RD     = '0;
        case (state_q)
            IDLE: begin
                if (EXC_REQ)       state_d = X_EPC;
                else if (RET_REQ)  state_d = R_STAT;
                else if (INST_REQ) state_d = I_ACC;
            end
            I_ACC: begin
                csr.CSR_CMD = cap_cmd;
                csr.CSR_A   = cap_a;
                csr.CSR_WD  = cap_wd;
                INST_ACK    = 1'b1;
                INST_RD     = csr.CSR_RD;
                state_d     = IDLE;
            end
            X_EPC: begin
                csr.CSR_CMD = `CSR_WRITE;
                csr.CSR_A   = 12'h341;
                csr.CSR_WD  = cap_pc;
                state_d     = X_CAUSE;
            end
            X_CAUSE: begin
                csr.CSR_CMD = `CSR_WRITE;
                csr.CSR_A   = 12'h342;
                csr.CSR_WD  = cap_cause;
`ifdef LEVE_TRAP_TVAL_EN
                state_d     = X_TVAL;
`else
                state_d     = X_STAT;
`endif
            end
`ifdef LEVE_TRAP_TVAL_EN
            X_TVAL: begin
                csr.CSR_CMD = `CSR_WRITE;
                csr.CSR_A   = 12'h343;
                csr.CSR_WD  = cap_tval;
                state_d     = X_STAT;
            end
`endif
            X_STAT: begin
                // MPIE <= MIE, MIE <= 0, MPP <= M; the rest of mstatus passes through.
                csr.CSR_CMD        = `CSR_WRITE;
                csr.CSR_A          = 12'h300;
                csr.CSR_WD         = csr.CSR_RD;
                csr.CSR_WD[7]      = csr.CSR_RD[3];
                csr.CSR_WD[3]      = 1'b0;
                csr.CSR_WD[12:11]  = 2'b11;
                state_d            = X_VEC;
            end
            X_VEC: begin
                csr.CSR_A = 12'h305;
                state_d   = DONE;
            end
            R_STAT: begin
                csr.CSR_CMD        = `CSR_WRITE;
                csr.CSR_A          = 12'h300;
                csr.CSR_WD         = csr.CSR_RD;
                csr.CSR_WD[3]      = csr.CSR_RD[7];
                csr.CSR_WD[7]      = 1'b1;
                csr.CSR_WD[12:11]  = 2'b00;
                state_d            = R_EPC;
            end
            R_EPC: begin
                csr.CSR_A = 12'h341;
                state_d   = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign BUSY        = (state_q != IDLE);
    assign REDIRECT    = (state_q == DONE);
    assign REDIRECT_PC = redirect_pc_q;

endmodule

// File: tb/tb_leve_trap_seq.sv
// Directed bench for leve_trap_seq with a small behavioural CSR file on the command port.
// Build with or without LEVE_TRAP_TVAL_EN; expected latency and mtval follow the define.
module tb_leve_trap_seq;
    localparam int XLEN = 64;
    localparam logic [1:0] C_NONE = 2'b00, C_SET = 2'b01, C_CLEAR = 2'b10, C_WRITE = 2'b11;
`ifdef LEVE_TRAP_TVAL_EN
    localparam int              EXC_LAT  = 6;
    localparam int              STAT_OFF = 4;
    localparam logic [XLEN-1:0] MTVAL_1  = 64'hdead;
    localparam logic [XLEN-1:0] MTVAL_3  = 64'h3;
`else
    localparam int              EXC_LAT  = 5;
    localparam int              STAT_OFF = 3;
    localparam logic [XLEN-1:0] MTVAL_1  = 64'h0;
    localparam logic [XLEN-1:0] MTVAL_3  = 64'h0;
`endif

    logic            CLK = 1'b0;
    logic            RSTn = 1'b0;
    logic            INST_REQ, EXC_REQ, RET_REQ;
    logic [1:0]      INST_CMD;
    logic [11:0]     INST_A;
    logic [XLEN-1:0] INST_WD, EXC_CAUSE, EXC_PC, EXC_TVAL;
    logic            INST_ACK, BUSY, REDIRECT;
    logic [XLEN-1:0] INST_RD, REDIRECT_PC;

    always #5 CLK = ~CLK;

    leve_trap_seq_if #(.XLEN(XLEN)) csr_bus ();

    leve_trap_seq #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .INST_REQ(INST_REQ), .INST_CMD(INST_CMD), .INST_A(INST_A), .INST_WD(INST_WD),
        .INST_ACK(INST_ACK), .INST_RD(INST_RD),
        .EXC_REQ(EXC_REQ), .EXC_CAUSE(EXC_CAUSE), .EXC_PC(EXC_PC), .EXC_TVAL(EXC_TVAL),
        .RET_REQ(RET_REQ), .BUSY(BUSY), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
        .csr(csr_bus.master)
    );

    // Behavioural CSR file: combinational read, write at the clock edge.
    logic [XLEN-1:0] m_mstatus = 64'h8;
    logic [XLEN-1:0] m_mtvec   = '0;
    logic [XLEN-1:0] m_mepc    = '0;
    logic [XLEN-1:0] m_mcause  = '0;
    logic [XLEN-1:0] m_mtval   = '0;

    function automatic logic [XLEN-1:0] csr_op(input logic [1:0] cmd, input logic [XLEN-1:0] old_v,
                                               input logic [XLEN-1:0] wd);
        case (cmd)
            C_SET:   return old_v | wd;
            C_CLEAR: return old_v & ~wd;
            C_WRITE: return wd;
            default: return old_v;
        endcase
    endfunction

    always_comb begin
        case (csr_bus.CSR_A)
            12'h300: csr_bus.CSR_RD = m_mstatus;
            12'h305: csr_bus.CSR_RD = m_mtvec;
            12'h341: csr_bus.CSR_RD = m_mepc;
            12'h342: csr_bus.CSR_RD = m_mcause;
            12'h343: csr_bus.CSR_RD = m_mtval;
            default: csr_bus.CSR_RD = '0;
        endcase
    end

    always @(posedge CLK) begin
        case (csr_bus.CSR_A)
            12'h300: m_mstatus <= csr_op(csr_bus.CSR_CMD, m_mstatus, csr_bus.CSR_WD);
            12'h305: m_mtvec   <= csr_op(csr_bus.CSR_CMD, m_mtvec,   csr_bus.CSR_WD);
            12'h341: m_mepc    <= csr_op(csr_bus.CSR_CMD, m_mepc,    csr_bus.CSR_WD);
            12'h342: m_mcause  <= csr_op(csr_bus.CSR_CMD, m_mcause,  csr_bus.CSR_WD);
            12'h343: m_mtval   <= csr_op(csr_bus.CSR_CMD, m_mtval,   csr_bus.CSR_WD);
            default: ;
        endcase
    end

    int redirect_cnt = 0;
    int ack_cnt = 0;
    always @(negedge CLK) begin
        if (REDIRECT) redirect_cnt <= redirect_cnt + 1;
        if (INST_ACK) ack_cnt <= ack_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at #1 after the edge that opens the request cycle N; returns the cycle offset of the
    // first ACK or REDIRECT (-1 if none within the budget) and which of the two it was.
    task automatic wait_done(input bit scramble, output int lat, output bit is_redir);
        lat = 0;
        is_redir = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge CLK);
            if (scramble && i == 1) begin
                #1;
                INST_CMD  = C_CLEAR;
                INST_A    = 12'hfff;
                INST_WD   = '1;
                EXC_CAUSE = '1;
                EXC_PC    = '1;
                EXC_TVAL  = '1;
            end
            @(negedge CLK);
            if (REDIRECT || INST_ACK) begin
                lat = i;
                is_redir = REDIRECT;
            end
        end
        if (lat == 0) lat = -1;
    endtask

    task automatic drop(input bit exc, input bit ret, input bit inst);
        @(posedge CLK);
        #1;
        if (exc)  EXC_REQ  = 1'b0;
        if (ret)  RET_REQ  = 1'b0;
        if (inst) INST_REQ = 1'b0;
    endtask

    int lat;
    bit kind;
    int base_r, base_a;

    initial begin
        INST_REQ = 1'b0; EXC_REQ = 1'b0; RET_REQ = 1'b0;
        INST_CMD = C_NONE; INST_A = '0; INST_WD = '0;
        EXC_CAUSE = '0; EXC_PC = '0; EXC_TVAL = '0;

        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", BUSY, 0);
        check("rst_redirect", REDIRECT, 0);
        check("rst_redirect_pc", REDIRECT_PC, 0);
        check("rst_inst_ack", INST_ACK, 0);
        check("rst_inst_rd", INST_RD, 0);
        check("rst_csr_cmd", csr_bus.CSR_CMD, C_NONE);
        check("rst_csr_a", csr_bus.CSR_A, 0);
        check("rst_csr_wd", csr_bus.CSR_WD, 0);
        @(posedge CLK); #1; RSTn = 1'b1;
        @(posedge CLK); #1;

        // CSR instruction write of mtvec, operands scrambled after acceptance
        INST_REQ = 1'b1; INST_CMD = C_WRITE; INST_A = 12'h305; INST_WD = 64'h8000_0103;
        wait_done(1'b1, lat, kind);
        check("wr_lat", lat, 1);
        check("wr_kind", kind, 0);
        check("wr_old_rd", INST_RD, 0);
        drop(0, 0, 1);
        check("wr_mtvec", m_mtvec, 64'h8000_0103);
        check("wr_busy_after", BUSY, 0);

        // CSR instruction read-only access of mtvec
        @(posedge CLK); #1;
        INST_REQ = 1'b1; INST_CMD = C_NONE; INST_A = 12'h305; INST_WD = '0;
        wait_done(1'b0, lat, kind);
        check("rd_lat", lat, 1);
        check("rd_val", INST_RD, 64'h8000_0103);
        drop(0, 0, 1);

        // Exception entry with MIE=1
        @(posedge CLK); #1;
        EXC_REQ = 1'b1; EXC_CAUSE = 64'h2; EXC_PC = 64'h1000; EXC_TVAL = 64'hdead;
        wait_done(1'b1, lat, kind);
        check("exc_lat", lat, EXC_LAT);
        check("exc_kind", kind, 1);
        check("exc_busy_done", BUSY, 1);
        check("exc_pc", REDIRECT_PC, 64'h8000_0100);
        drop(1, 0, 0);
        check("exc_redirect_1cyc", REDIRECT, 0);
        check("exc_busy_after", BUSY, 0);
        check("exc_mepc", m_mepc, 64'h1000);
        check("exc_mcause", m_mcause, 64'h2);
        check("exc_mtval", m_mtval, MTVAL_1);
        check("exc_mstatus", m_mstatus, 64'h1880);

        // MRET
        @(posedge CLK); #1;
        RET_REQ = 1'b1;
        wait_done(1'b1, lat, kind);
        check("ret_lat", lat, 3);
        check("ret_kind", kind, 1);
        check("ret_pc", REDIRECT_PC, 64'h1000);
        drop(0, 1, 0);
        check("ret_mstatus", m_mstatus, 64'h88);
        check("ret_pc_held", REDIRECT_PC, 64'h1000);

        // All three requests together: exception, then MRET, then instruction
        @(posedge CLK); #1;
        base_r = redirect_cnt; base_a = ack_cnt;
        EXC_REQ = 1'b1; EXC_CAUSE = 64'hb; EXC_PC = 64'h2000; EXC_TVAL = 64'h1;
        RET_REQ = 1'b1;
        INST_REQ = 1'b1; INST_CMD = C_WRITE; INST_A = 12'h342; INST_WD = 64'h77;
        wait_done(1'b0, lat, kind);
        check("pri1_kind", kind, 1);
        check("pri1_pc", REDIRECT_PC, 64'h8000_0100);
        drop(1, 0, 0);
        wait_done(1'b0, lat, kind);
        check("pri2_kind", kind, 1);
        check("pri2_pc", REDIRECT_PC, 64'h2000);
        drop(0, 1, 0);
        wait_done(1'b0, lat, kind);
        check("pri3_kind", kind, 0);
        check("pri3_old_mcause", INST_RD, 64'hb);
        drop(0, 0, 1);
        repeat (3) @(posedge CLK); #1;
        check("pri_redirects", redirect_cnt - base_r, 2);
        check("pri_acks", ack_cnt - base_a, 1);
        check("pri_mcause", m_mcause, 64'h77);
        check("pri_mstatus", m_mstatus, 64'h88);

        // Reset while in X_STAT
        base_r = redirect_cnt;
        EXC_REQ = 1'b1; EXC_CAUSE = 64'h7; EXC_PC = 64'h3000; EXC_TVAL = 64'h3;
        repeat (STAT_OFF) @(posedge CLK);
        @(negedge CLK);
        check("xs_cmd", csr_bus.CSR_CMD, C_WRITE);
        check("xs_addr", csr_bus.CSR_A, 12'h300);
        RSTn = 1'b0; EXC_REQ = 1'b0;
        #1;
        check("xs_rst_busy", BUSY, 0);
        check("xs_rst_redirect", REDIRECT, 0);
        check("xs_rst_cmd", csr_bus.CSR_CMD, C_NONE);
        @(posedge CLK); #1;
        check("xs_mstatus_kept", m_mstatus, 64'h88);
        check("xs_mepc", m_mepc, 64'h3000);
        check("xs_mcause", m_mcause, 64'h7);
        check("xs_mtval", m_mtval, MTVAL_3);
        RSTn = 1'b1;
        repeat (8) @(posedge CLK); #1;
        check("xs_no_redirect", redirect_cnt - base_r, 0);
        check("xs_idle", BUSY, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
